inst_aligner: RTL and testbench

- Successor to the combinational x86 length decoder, extended to a sequential front-end stage.
- Buffers the prefetch byte stream in a circular byte queue of parametrised depth and input width.
- Strips up to MAX_PFX prefixes and decodes total instruction length, optionally including the 80186 opcode extensions.
- Issues one aligned instruction per cycle to the decoder over a valid/ready handshake. Sits between the bus prefetch unit and the microcode decoder.

---
 rtl/inst_aligner_if.sv | 31 +++
 rtl/inst_aligner.sv | 225 ++++++++++++++++++++++
 tb/tb_inst_aligner.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_aligner_if.sv
// Prefetch-to-decoder bus for the instruction aligner: byte-stream input beats and
// aligned-instruction output, each with its own valid/ready pair.
interface inst_aligner_if #(
   parameter int unsigned IN_BYTES = 2,
   parameter int unsigned DEPTH    = 16,
   parameter int unsigned MAX_PFX  = 4
) ();
   logic [8*IN_BYTES-1:0]      iData;
   logic                       iDataValid;
   logic                       oDataReady;
   logic [8*(MAX_PFX+6)-1:0]   oInst;
   logic [3:0]                 oInstLen;
   logic [2:0]                 oPfxCnt;
   logic                       oMod;
   logic                       oPfxOvf;
   logic                       oValid;
   logic                       iReady;
   logic [$clog2(DEPTH+1)-1:0] oFill;

   // Prefetch unit / decoder side
   modport master (
      output iData, iDataValid, iReady,
      input  oDataReady, oInst, oInstLen, oPfxCnt, oMod, oPfxOvf, oValid, oFill
   );

   // Aligner side
   modport slave (
      input  iData, iDataValid, iReady,
      output oDataReady, oInst, oInstLen, oPfxCnt, oMod, oPfxOvf, oValid, oFill
   );
endinterface

// File: rtl/inst_aligner.sv
// x86 front-end aligner: circular byte queue fed by the prefetch unit, prefix scan and
// length decode at the queue head, one registered aligned instruction per cycle.
module inst_aligner #(
   parameter int unsigned IN_BYTES = 2,
   parameter int unsigned DEPTH    = 16,
   parameter int unsigned MAX_PFX  = 4,
   parameter bit          EN_186   = 1'b0
) (
   input logic           iClk,
   input logic           iRst,
   input logic           iFlush,
   inst_aligner_if.slave bus
);
   localparam int unsigned PtrW  = $clog2(DEPTH);
   localparam int unsigned FillW = $clog2(DEPTH + 1);
   localparam int unsigned WinB  = MAX_PFX + 6;
   localparam int unsigned IdxW  = $clog2(WinB);

   // Queue storage and pointers
   logic [7:0]       mem_q [DEPTH];
   logic [7:0]       mem_d [DEPTH];
   logic [PtrW-1:0]  rd_q, rd_d, wr_q, wr_d;
   logic [FillW-1:0] fill_q, fill_d;
   // Set for one cycle after a beat is written; those bytes are hidden from the scanner
   logic             fresh_q, fresh_d;

   // Output register
   logic [8*WinB-1:0] inst_q, inst_d;
   logic [3:0]        len_q, len_d;
   logic [2:0]        pfx_q, pfx_d;
   logic              mod_q, mod_d;
   logic              ovf_q, ovf_d;
   logic              valid_q, valid_d;

   // Head decode
   logic [FillW-1:0] avail;
   logic [7:0]       win [WinB];
   logic [2:0]       scan_cnt;
   logic             run;
   logic [IdxW-1:0]  op_idx, mr_idx;
   logic [7:0]       opcode, modrm;
   logic             mod_hit, ovf_hit, complete;
   logic [2:0]       core_len;
   logic [3:0]       total;
   logic             data_ready, push, pop;

   function automatic logic is_pfx(input logic [7:0] b);
      return (b == 8'h26) || (b == 8'h2E) || (b == 8'h36) || (b == 8'h3E) ||
             (b == 8'hF0) || (b == 8'hF2) || (b == 8'hF3);
   endfunction

   // FE/FF fall inside the op&F6==F6 pattern
   function automatic logic has_modrm(input logic [7:0] op);
      logic m;
      m = ((op & 8'hC4) == 8'h00) || ((op & 8'hF0) == 8'h80) || ((op & 8'hFC) == 8'hC4) ||
          ((op & 8'hFC) == 8'hD0) || ((op & 8'hF8) == 8'hD8) || ((op & 8'hF6) == 8'hF6);
      if (EN_186) begin
         m = m || (op == 8'h62) || (op == 8'h69) || (op == 8'h6B) ||
             (op == 8'hC0) || (op == 8'hC1);
      end
      return m;
   endfunction

   // Opcode + ModRM + immediate, then 16-bit addressing displacement
   function automatic logic [2:0] modrm_len(input logic [7:0] op, input logic [7:0] mr);
      logic [2:0] base;
      logic [2:0] disp;
      if ((op == 8'h81) || (op == 8'hC7) || (EN_186 && (op == 8'h69))) begin
         base = 3'd4;
      end else if ((op == 8'h80) || (op == 8'h82) || (op == 8'h83) || (op == 8'hC6) ||
                   (EN_186 && ((op == 8'hC0) || (op == 8'hC1) || (op == 8'h6B)))) begin
         base = 3'd3;
      end else if ((op == 8'hF6) && (mr[5:3] == 3'b000)) begin
         base = 3'd3;
      end else if ((op == 8'hF7) && (mr[5:3] == 3'b000)) begin
         base = 3'd4;
      end else begin
         base = 3'd2;
      end
      case (mr[7:6])
         2'b00:   disp = (mr[2:0] == 3'b110) ? 3'd2 : 3'd0;
         2'b01:   disp = 3'd1;
         2'b10:   disp = 3'd2;
         default: disp = 3'd0;
      endcase
      return base + disp;
   endfunction

   function automatic logic [2:0] plain_len(input logic [7:0] op);
      logic [2:0] n;
      n = 3'd1;
      if ((op == 8'h9A) || (op == 8'hEA)) begin
         n = 3'd5;
      end else if (EN_186 && (op == 8'hC8)) begin
         n = 3'd4;
      end else if (((op & 8'hC7) == 8'h05) || ((op & 8'hFC) == 8'hA0) || (op == 8'hA9) ||
                   ((op & 8'hF8) == 8'hB8) || (op == 8'hC2) || (op == 8'hCA) ||
                   (op == 8'hE8) || (op == 8'hE9) || (EN_186 && (op == 8'h68))) begin
         n = 3'd3;
      end else if (((op & 8'hC7) == 8'h04) || ((op & 8'hF0) == 8'h70) || (op == 8'hA8) ||
                   ((op & 8'hF8) == 8'hB0) || (op == 8'hCD) || (op == 8'hD4) ||
                   (op == 8'hD5) || ((op & 8'hF8) == 8'hE0) || (op == 8'hEB) ||
                   (EN_186 && (op == 8'h6A))) begin
         n = 3'd2;
      end
      return n;
   endfunction

   // Prefix scan and length decode over the bytes visible at the queue head
   always_comb begin
      avail = fresh_q ? (fill_q - FillW'(IN_BYTES)) : fill_q;
      for (int i = 0; i < WinB; i++) begin
         win[i] = mem_q[rd_q + PtrW'(i)];
      end
      scan_cnt = 3'd0;
      run      = 1'b1;
      for (int i = 0; i < MAX_PFX; i++) begin
         if (run && (FillW'(i) < avail) && is_pfx(win[i])) begin
            scan_cnt = scan_cnt + 3'd1;
         end else begin
            run = 1'b0;
         end
      end
      op_idx   = IdxW'(scan_cnt);
      mr_idx   = op_idx + IdxW'(1);
      opcode   = win[op_idx];
      modrm    = win[mr_idx];
      mod_hit  = has_modrm(opcode);
      core_len = mod_hit ? modrm_len(opcode, modrm) : plain_len(opcode);
      // A full set of prefixes followed by yet another prefix issues on its own
      ovf_hit  = (scan_cnt == 3'(MAX_PFX)) && (avail > FillW'(MAX_PFX)) &&
                 is_pfx(win[MAX_PFX]);
      total    = ovf_hit ? 4'(MAX_PFX) : ({1'b0, scan_cnt} + {1'b0, core_len});
      complete = ovf_hit ||
                 ((avail >= (FillW'(scan_cnt) + FillW'(mod_hit) + FillW'(1))) &&
                  (avail >= FillW'(total)));
      // Readiness looks only at registered fill; a same-cycle pop earns no credit
      data_ready = (FillW'(DEPTH) - fill_q) >= FillW'(IN_BYTES);
      push       = bus.iDataValid && data_ready;
      pop        = complete && (!valid_q || bus.iReady);
   end

   // Queue push/pop, output register load and flush
   always_comb begin
      mem_d   = mem_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      fill_d  = fill_q;
      fresh_d = 1'b0;
      inst_d  = inst_q;
      len_d   = len_q;
      pfx_d   = pfx_q;
      mod_d   = mod_q;
      ovf_d   = ovf_q;
      valid_d = valid_q;
      if (iFlush) begin
         rd_d    = wr_q;
         fill_d  = '0;
         valid_d = 1'b0;
      end else begin
         if (push) begin
            for (int k = 0; k < IN_BYTES; k++) begin
               mem_d[wr_q + PtrW'(k)] = bus.iData[8*k +: 8];
            end
            wr_d    = wr_q + PtrW'(IN_BYTES);
            fresh_d = 1'b1;
         end
         if (pop) begin
            rd_d = rd_q + PtrW'(total);
            for (int i = 0; i < WinB; i++) begin
               inst_d[8*i +: 8] = win[i];
            end
            len_d   = total;
            pfx_d   = ovf_hit ? 3'(MAX_PFX) : scan_cnt;
            mod_d   = mod_hit && !ovf_hit;
            ovf_d   = ovf_hit;
            valid_d = 1'b1;
         end else if (bus.iReady) begin
            valid_d = 1'b0;
         end
         fill_d = fill_q + (push ? FillW'(IN_BYTES) : '0) - (pop ? FillW'(total) : '0);
      end
   end

   // Queue byte storage; contents are only meaningful between the pointers
   always_ff @(posedge iClk) begin
      mem_q <= mem_d;
   end

   // Pointer, fill and output state
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         rd_q    <= '0;
         wr_q    <= '0;
         fill_q  <= '0;
         fresh_q <= 1'b0;
         inst_q  <= '0;
         len_q   <= '0;
         pfx_q   <= '0;
         mod_q   <= 1'b0;
         ovf_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         fill_q  <= fill_d;
         fresh_q <= fresh_d;
         inst_q  <= inst_d;
         len_q   <= len_d;
         pfx_q   <= pfx_d;
         mod_q   <= mod_d;
         ovf_q   <= ovf_d;
         valid_q <= valid_d;
      end
   end

   assign bus.oDataReady = data_ready;
   assign bus.oInst      = inst_q;
   assign bus.oInstLen   = len_q;
   assign bus.oPfxCnt    = pfx_q;
   assign bus.oMod       = mod_q;
   assign bus.oPfxOvf    = ovf_q;
   assign bus.oValid     = valid_q;
   assign bus.oFill      = fill_q;
endmodule

// File: tb/tb_inst_aligner.sv
// Directed bench for inst_aligner: two instances (80186 rules on and off) share one
// input stream; issued instructions are captured per instance and checked in order.
module tb_inst_aligner;
   localparam int unsigned InBytes = 2;
   localparam int unsigned Depth   = 16;
   localparam int unsigned MaxPfx  = 4;

   typedef struct {
      logic [79:0] inst;
      logic [3:0]  len;
      logic [2:0]  pfx;
      logic        mod;
      logic        ovf;
      int          cyc;
   } rec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        din_valid = 1'b0;
   logic        rdy_in = 1'b1;
   logic [15:0] din = 16'h0;
   int          cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   int          first_acc = 0;
   logic [7:0]  tx[$];
   rec_t        sb0[$];
   rec_t        sb1[$];

   inst_aligner_if #(.IN_BYTES(InBytes), .DEPTH(Depth), .MAX_PFX(MaxPfx)) bus0 ();
   inst_aligner_if #(.IN_BYTES(InBytes), .DEPTH(Depth), .MAX_PFX(MaxPfx)) bus1 ();

   assign bus0.iData      = din;
   assign bus0.iDataValid = din_valid;
   assign bus0.iReady     = rdy_in;
   assign bus1.iData      = din;
   assign bus1.iDataValid = din_valid;
   assign bus1.iReady     = rdy_in;

   inst_aligner #(.IN_BYTES(InBytes), .DEPTH(Depth), .MAX_PFX(MaxPfx), .EN_186(1'b1)) dut0 (
      .iClk  (clk),
      .iRst  (rst),
      .iFlush(flush),
      .bus   (bus0)
   );

   inst_aligner #(.IN_BYTES(InBytes), .DEPTH(Depth), .MAX_PFX(MaxPfx), .EN_186(1'b0)) dut1 (
      .iClk  (clk),
      .iRst  (rst),
      .iFlush(flush),
      .bus   (bus1)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Capture every accepted instruction; the handshake completes at the next rising edge
   always @(negedge clk) begin
      if (!rst && !flush && rdy_in && bus0.oValid)
         sb0.push_back(rec_t'{bus0.oInst, bus0.oInstLen, bus0.oPfxCnt, bus0.oMod,
                              bus0.oPfxOvf, cyc});
      if (!rst && !flush && rdy_in && bus1.oValid)
         sb1.push_back(rec_t'{bus1.oInst, bus1.oInstLen, bus1.oPfxCnt, bus1.oMod,
                              bus1.oPfxOvf, cyc});
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [79:0] lmask(input int n);
      logic [79:0] m;
      m = '0;
      for (int i = 0; i < n; i++) m[8*i +: 8] = 8'hFF;
      return m;
   endfunction

   // Stream tx as 2-byte beats (low byte oldest); first_acc = cycle of first accepted beat
   task automatic send();
      logic rdy;
      int   guard;
      bit   first;
      first = 1'b1;
      while (tx.size() >= 2) begin
         din       = {tx[1], tx[0]};
         din_valid = 1'b1;
         guard     = 0;
         rdy       = 1'b0;
         while (!rdy && guard < 200) begin
            @(negedge clk);
            rdy = bus0.oDataReady;
            @(posedge clk);
            #1;
            guard++;
         end
         if (!rdy) begin
            check("send accept", {79'h0, rdy}, 80'h1);
            tx.delete();
         end else begin
            if (first) first_acc = cyc;
            first = 1'b0;
            void'(tx.pop_front());
            void'(tx.pop_front());
         end
      end
      din_valid = 1'b0;
   endtask

   task automatic wait_sb(input int which, input int n);
      int sz;
      sz = 0;
      for (int i = 0; i < 200; i++) begin
         sz = (which == 0) ? sb0.size() : sb1.size();
         if (sz >= n) break;
         @(posedge clk);
         #1;
      end
      check($sformatf("dut%0d issue count>=%0d (got %0d)", which, n, sz),
            {79'h0, (sz >= n)}, 80'h1);
   endtask

   task automatic pulse_flush();
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
   endtask

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst oValid", bus0.oValid, 0);
      check("rst oFill", bus0.oFill, 0);
      check("rst oInst", bus0.oInst, 0);
      check("rst oInstLen", bus0.oInstLen, 0);
      check("rst oPfxCnt", bus0.oPfxCnt, 0);
      check("rst oMod", bus0.oMod, 0);
      check("rst oPfxOvf", bus0.oPfxOvf, 0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("ready after reset", bus0.oDataReady, 1);

      // 1: four single-byte NOPs, back to back, 2-edge latency
      sb0.delete(); sb1.delete();
      tx = '{8'h90, 8'h90, 8'h90, 8'h90};
      send();
      wait_sb(0, 4);
      check("t1 first latency", sb0[0].cyc, first_acc + 2);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("t1 len%0d", i), sb0[i].len, 1);
         check($sformatf("t1 mod%0d", i), sb0[i].mod, 0);
         check($sformatf("t1 byte%0d", i), sb0[i].inst[7:0], 8'h90);
      end
      for (int i = 1; i < 4; i++)
         check($sformatf("t1 cycle%0d", i), sb0[i].cyc, first_acc + 2 + i);
      repeat (2) @(posedge clk);
      #1;
      check("t1 fill empty", bus0.oFill, 0);

      // 2: segment prefix + MOV r16,[bp+disp16]
      sb0.delete(); sb1.delete();
      tx = '{8'h2E, 8'h8B, 8'h86, 8'h34, 8'h12, 8'h90};
      send();
      wait_sb(0, 2);
      check("t2 len", sb0[0].len, 5);
      check("t2 pfx", sb0[0].pfx, 1);
      check("t2 mod", sb0[0].mod, 1);
      check("t2 ovf", sb0[0].ovf, 0);
      check("t2 inst", sb0[0].inst & lmask(5), 80'h12_34_86_8B_2E);
      check("t2 pad len", sb0[1].len, 1);

      // 3: five prefixes -> overflow group of four, then 3E A4
      sb0.delete(); sb1.delete();
      tx = '{8'hF3, 8'h26, 8'hF0, 8'h2E, 8'h3E, 8'hA4};
      send();
      wait_sb(0, 2);
      check("t3 ovf", sb0[0].ovf, 1);
      check("t3 ovf len", sb0[0].len, 4);
      check("t3 ovf pfx", sb0[0].pfx, 4);
      check("t3 ovf mod", sb0[0].mod, 0);
      check("t3 ovf inst", sb0[0].inst & lmask(4), 80'h2E_F0_26_F3);
      check("t3 2nd ovf", sb0[1].ovf, 0);
      check("t3 2nd pfx", sb0[1].pfx, 1);
      check("t3 2nd len", sb0[1].len, 2);
      check("t3 2nd inst", sb0[1].inst & lmask(2), 80'hA4_3E);

      // 4: ENTER and IMUL imm8 with and without 80186 rules
      sb0.delete(); sb1.delete();
      tx = '{8'hC8, 8'h10, 8'h00, 8'h01, 8'h6B, 8'hC0, 8'h05, 8'h90};
      send();
      wait_sb(0, 3);
      wait_sb(1, 1);
      check("t4 enter len", sb0[0].len, 4);
      check("t4 enter mod", sb0[0].mod, 0);
      check("t4 enter inst", sb0[0].inst & lmask(4), 80'h01_00_10_C8);
      check("t4 imul len", sb0[1].len, 3);
      check("t4 imul mod", sb0[1].mod, 1);
      check("t4 imul inst", sb0[1].inst & lmask(3), 80'h05_C0_6B);
      check("t4 pad len", sb0[2].len, 1);
      check("t4 no186 C8 len", sb1[0].len, 1);
      check("t4 no186 C8 byte", sb1[0].inst[7:0], 8'hC8);
      pulse_flush();
      check("t4 no186 fill after flush", bus1.oFill, 0);

      // 5: stall output and fill the queue; nothing lost or duplicated
      sb0.delete(); sb1.delete();
      rdy_in = 1'b0;
      for (int i = 0; i < 16; i++) tx.push_back(8'(8'h40 + i));
      send();
      repeat (3) @(posedge clk);
      #1;
      check("t5 fill full", bus0.oFill, 15);
      check("t5 ready low", bus0.oDataReady, 0);
      check("t5 valid held", bus0.oValid, 1);
      check("t5 head byte", bus0.oInst[7:0], 8'h40);
      repeat (3) @(posedge clk);
      #1;
      check("t5 head stable", bus0.oInst[7:0], 8'h40);
      check("t5 len stable", bus0.oInstLen, 1);
      check("t5 fill stable", bus0.oFill, 15);
      rdy_in = 1'b1;
      for (int i = 16; i < 20; i++) tx.push_back(8'(8'h40 + i));
      send();
      wait_sb(0, 20);
      for (int i = 0; i < 20; i++)
         check($sformatf("t5 order%0d", i), sb0[i].inst[7:0], 8'(8'h40 + i));
      repeat (2) @(posedge clk);
      #1;
      check("t5 drained", bus0.oFill, 0);

      // 6: flush with valid output, wrapped pointers and a beat in the same cycle
      rdy_in = 1'b0;
      tx = '{8'h90, 8'h90};
      send();
      for (int i = 0; i < 10 && !bus0.oValid; i++) begin
         @(posedge clk);
         #1;
      end
      check("t6 valid before flush", bus0.oValid, 1);
      din       = 16'h9090;
      din_valid = 1'b1;
      pulse_flush();
      din_valid = 1'b0;
      check("t6 fill after flush", bus0.oFill, 0);
      check("t6 valid after flush", bus0.oValid, 0);
      @(posedge clk);
      #1;
      check("t6 beat dropped", bus0.oFill, 0);
      sb0.delete(); sb1.delete();
      rdy_in = 1'b1;
      tx = '{8'hF7, 8'h06, 8'h00, 8'h10, 8'h34, 8'h12};
      send();
      wait_sb(0, 1);
      check("t6 len", sb0[0].len, 6);
      check("t6 mod", sb0[0].mod, 1);
      check("t6 pfx", sb0[0].pfx, 0);
      check("t6 inst", sb0[0].inst & lmask(6), 80'h12_34_10_00_06_F7);

      // 7: asynchronous reset in mid-cycle drops everything at once
      rdy_in = 1'b0;
      tx = '{8'h90, 8'h90};
      send();
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("t7 async valid", bus0.oValid, 0);
      check("t7 async fill", bus0.oFill, 0);
      check("t7 async len", bus0.oInstLen, 0);

      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end
endmodule
